// File: rtl/bp_lce_req_arb_pkg.sv
// Shared types for the LCE request arbiter: the opaque LCE->CCE request payload and its widths.
package bp_lce_req_arb_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_inv_cfg
    } bp_params_e;

    localparam int paddr_width_gp  = 40;
    localparam int lce_id_width_gp = 4;
    localparam int cce_id_width_gp = 4;
    localparam int req_data_width_gp = 64;

    typedef enum logic [2:0] {
        e_lce_req_type_rd,
        e_lce_req_type_wr,
        e_lce_req_type_uc_rd,
        e_lce_req_type_uc_wr
    } bp_lce_cce_req_type_e;

    typedef struct packed {
        bp_lce_cce_req_type_e        msg_type;
        logic [lce_id_width_gp-1:0]  src_id;
        logic [cce_id_width_gp-1:0]  dst_id;
        logic [paddr_width_gp-1:0]   addr;
    } bp_lce_cce_req_hdr_s;

    typedef struct packed {
        bp_lce_cce_req_hdr_s           hdr;
        logic [req_data_width_gp-1:0]  data;
    } bp_lce_cce_req_s;

    localparam int lce_cce_req_width_gp = $bits(bp_lce_cce_req_s);

endpackage

// File: rtl/bp_lce_req_arb_slot.sv
// One-entry ready->valid holding buffer; ready reflects registered emptiness only.
module bp_lce_req_arb_slot
    import bp_lce_req_arb_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  bp_lce_cce_req_s data_i,
    input  logic            v_i,
    output logic            ready_o,
    output bp_lce_cce_req_s data_o,
    output logic            v_o,
    input  logic            yumi_i
);

    logic            v_r;
    bp_lce_cce_req_s data_r;

    assign ready_o = ~v_r & ~reset_i;
    assign v_o     = v_r;
    assign data_o  = data_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            v_r <= 1'b0;
        else if (v_i & ready_o)
            v_r <= 1'b1;
        else if (yumi_i)
            v_r <= 1'b0;
    end

    // NOTE: the payload register has no reset; v_r alone decides whether its contents are used.
    always_ff @(posedge clk_i) begin
        if (v_i & ready_o)
            data_r <= data_i;
    end

    enq_protocol_a: assert property (@(posedge clk_i) disable iff (reset_i) !(v_i && !ready_o))
        else $error("lce request valid asserted while slot not ready");

endmodule

// File: rtl/bp_lce_req_arbiter.sv
// Round-robin share of one LCE request port among num_req_p one-entry slots.
// Optional per-requester send counters: define BP_LCE_REQ_ARB_STATS_EN.
module bp_lce_req_arbiter
    import bp_lce_req_arb_pkg::*;
#(
    parameter bp_params_e bp_params_p  = e_bp_inv_cfg,
    parameter int         num_req_p    = 2,
    parameter int         stat_width_p = 32
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_req_p*lce_cce_req_width_gp-1:0]  lce_req_i,
    input  logic [num_req_p-1:0]                       lce_req_v_i,
    output logic [num_req_p-1:0]                       lce_req_ready_o,
    output logic [lce_cce_req_width_gp-1:0]            lce_req_o,
    output logic                                       lce_req_v_o,
    input  logic                                       lce_req_ready_i,
    output logic [num_req_p*stat_width_p-1:0]          sent_count_o
);

    localparam int ptr_width_lp = $clog2(num_req_p);
    typedef logic [ptr_width_lp-1:0] ptr_t;
    localparam logic [ptr_width_lp:0] num_req_lp = (ptr_width_lp+1)'(num_req_p);

    bp_lce_cce_req_s        slot_data [num_req_p];
    logic [num_req_p-1:0]   slot_v;
    logic [num_req_p-1:0]   slot_yumi;
    logic [num_req_p-1:0]   rot_v;
    logic [ptr_width_lp:0]  grant_sum;
    ptr_t                   rr_ptr_r, offset, grant;
    logic                   send;

    for (genvar i = 0; i < num_req_p; i++) begin : g_slot
        bp_lce_req_arb_slot slot (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (lce_req_i[i*lce_cce_req_width_gp +: lce_cce_req_width_gp]),
            .v_i     (lce_req_v_i[i]),
            .ready_o (lce_req_ready_o[i]),
            .data_o  (slot_data[i]),
            .v_o     (slot_v[i]),
            .yumi_i  (slot_yumi[i])
        );
    end

    // Rotate so rr_ptr_r sits at bit 0, priority-encode, then rotate the offset back.
    // NOTE: every always_comb output is defaulted before any conditional write, so no latch is inferred.
    always_comb begin
        rot_v  = num_req_p'({slot_v, slot_v} >> rr_ptr_r);
        offset = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (rot_v[k])
                offset = ptr_t'(k);
        end
        grant_sum = {1'b0, rr_ptr_r} + {1'b0, offset};
        if (grant_sum >= num_req_lp)
            grant_sum = grant_sum - num_req_lp;
        grant = grant_sum[ptr_width_lp-1:0];
    end

    assign send        = lce_req_ready_i & (|slot_v) & ~reset_i;
    assign lce_req_v_o = send;
    assign lce_req_o   = slot_data[grant];

    always_comb begin
        slot_yumi        = '0;
        slot_yumi[grant] = send;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            rr_ptr_r <= '0;
        else if (send)
            rr_ptr_r <= (grant == ptr_t'(num_req_p - 1)) ? '0 : grant + 1'b1;
    end

`ifdef BP_LCE_REQ_ARB_STATS_EN
    logic [stat_width_p-1:0] sent_cnt_r [num_req_p];

    for (genvar i = 0; i < num_req_p; i++) begin : g_stat
        always_ff @(posedge clk_i) begin
            if (reset_i)
                sent_cnt_r[i] <= '0;
            else if (slot_yumi[i] && !(&sent_cnt_r[i]))
                sent_cnt_r[i] <= sent_cnt_r[i] + 1'b1;
        end
        assign sent_count_o[i*stat_width_p +: stat_width_p] = sent_cnt_r[i];
    end
`else
    assign sent_count_o = '0;
`endif

    cfg_supported_a: assert property (@(posedge clk_i) bp_params_p == e_bp_inv_cfg)
        else $error("unsupported processor configuration");

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Bench for bp_lce_req_arbiter: a 2-requester and a 3-requester instance against a slot/round-robin model.
module tb_bp_lce_req_arbiter;
    import bp_lce_req_arb_pkg::*;

    localparam int W = lce_cce_req_width_gp;
    typedef logic [paddr_width_gp-1:0] paddr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a = 1'b1, rdy_i_a = 1'b0, vo_a;
    logic [2*W-1:0] req_a = '0;
    logic [1:0]     v_a = '0, rdyo_a;
    logic [W-1:0]   out_a;
    logic [63:0]    cnt_a;

    logic           rst_b = 1'b1, rdy_i_b = 1'b0, vo_b;
    logic [3*W-1:0] req_b = '0;
    logic [2:0]     v_b = '0, rdyo_b;
    logic [W-1:0]   out_b;
    logic [11:0]    cnt_b;

    bp_lce_req_arbiter #(.num_req_p(2), .stat_width_p(32)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .lce_req_i(req_a), .lce_req_v_i(v_a),
        .lce_req_ready_o(rdyo_a), .lce_req_o(out_a), .lce_req_v_o(vo_a),
        .lce_req_ready_i(rdy_i_a), .sent_count_o(cnt_a));

    bp_lce_req_arbiter #(.num_req_p(3), .stat_width_p(4)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .lce_req_i(req_b), .lce_req_v_i(v_b),
        .lce_req_ready_o(rdyo_b), .lce_req_o(out_b), .lce_req_v_o(vo_b),
        .lce_req_ready_i(rdy_i_b), .sent_count_o(cnt_b));

    int errors = 0, checks = 0, cyc = 0;
    int nreq [2] = '{2, 3};
    longint cmax [2] = '{64'hFFFF_FFFF, 15};

    // Stimulus requested by the scenario, and what was actually driven this cycle.
    logic [2:0]      drv_v [2];
    logic            drv_rdy [2], drv_rst [2];
    bp_lce_cce_req_s drv_d [2][3];
    logic [2:0]      cur_v [2];
    logic            cur_rdy [2], cur_rst [2];
    bp_lce_cce_req_s cur_d [2][3];

    // Reference model: per-slot occupancy, payloads, round-robin pointer, send counts.
    logic            m_v [2][3];
    bp_lce_cce_req_s m_d [2][3];
    int              m_ptr [2];
    longint          m_cnt [2][3];

    function automatic int m_grant(int id);
        for (int k = 0; k < nreq[id]; k++) begin
            int idx = (m_ptr[id] + k) % nreq[id];
            if (m_v[id][idx]) return idx;
        end
        return -1;
    endfunction

    function automatic longint exp_cnt(int id, int i);
`ifdef BP_LCE_REQ_ARB_STATS_EN
        return m_cnt[id][i];
`else
        return 0;
`endif
    endfunction

    function automatic bp_lce_cce_req_s mk_req(int tag, int seq, paddr_t addr);
        bp_lce_cce_req_s r;
        r.hdr.msg_type = bp_lce_cce_req_type_e'(3'(seq % 4));
        r.hdr.src_id   = 4'(tag);
        r.hdr.dst_id   = 4'(seq);
        r.hdr.addr     = addr;
        r.data         = {8'(tag), 24'(seq), 32'($urandom())};
        return r;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_ptr[id] = 0;
            for (int i = 0; i < 3; i++) begin
                m_v[id][i] = 1'b0;
                m_cnt[id][i] = 0;
                m_d[id][i] = '0;
            end
        end
    endtask

    // Drive on the falling edge, then compare both DUTs against the model.
    task automatic drive_sample();
        logic [2:0] exp_rdy, obs_rdy;
        logic exp_vo, obs_vo;
        logic [W-1:0] obs_out;
        longint obs_c;
        int g;
        @(negedge clk);
        for (int id = 0; id < 2; id++) begin
            cur_rst[id] = drv_rst[id];
            cur_rdy[id] = drv_rdy[id];
            cur_v[id]   = '0;
            for (int i = 0; i < nreq[id]; i++) begin
                cur_d[id][i] = drv_d[id][i];
                cur_v[id][i] = drv_v[id][i] && !m_v[id][i] && !drv_rst[id];
            end
        end
        rst_a = cur_rst[0]; rdy_i_a = cur_rdy[0]; v_a = cur_v[0][1:0];
        for (int i = 0; i < 2; i++) req_a[i*W +: W] = cur_d[0][i];
        rst_b = cur_rst[1]; rdy_i_b = cur_rdy[1]; v_b = cur_v[1];
        for (int i = 0; i < 3; i++) req_b[i*W +: W] = cur_d[1][i];
        #1;
        for (int id = 0; id < 2; id++) begin
            exp_rdy = '0;
            for (int i = 0; i < nreq[id]; i++) exp_rdy[i] = !cur_rst[id] && !m_v[id][i];
            obs_rdy = (id == 0) ? {1'b0, rdyo_a} : rdyo_b;
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL sb_ready dut%0d cyc%0d: got %b expected %b", id, cyc, obs_rdy, exp_rdy);
            end
            g = m_grant(id);
            exp_vo = !cur_rst[id] && cur_rdy[id] && (g >= 0);
            obs_vo = (id == 0) ? vo_a : vo_b;
            checks++;
            if (obs_vo !== exp_vo) begin
                errors++;
                $display("FAIL sb_valid dut%0d cyc%0d: got %b expected %b", id, cyc, obs_vo, exp_vo);
            end
            if (exp_vo) begin
                obs_out = (id == 0) ? out_a : out_b;
                checks++;
                if (obs_out !== W'(m_d[id][g])) begin
                    errors++;
                    $display("FAIL sb_payload dut%0d cyc%0d: got %h expected %h (slot %0d)", id, cyc, obs_out, m_d[id][g], g);
                end
            end
            for (int i = 0; i < nreq[id]; i++) begin
                obs_c = (id == 0) ? longint'(cnt_a[i*32 +: 32]) : longint'(cnt_b[i*4 +: 4]);
                checks++;
                if (obs_c != exp_cnt(id, i)) begin
                    errors++;
                    $display("FAIL sb_count dut%0d slot%0d cyc%0d: got %0d expected %0d", id, i, cyc, obs_c, exp_cnt(id, i));
                end
            end
        end
    endtask

    task automatic advance();
        int g;
        @(posedge clk);
        for (int id = 0; id < 2; id++) begin
            if (cur_rst[id]) begin
                m_ptr[id] = 0;
                for (int i = 0; i < 3; i++) begin m_v[id][i] = 1'b0; m_cnt[id][i] = 0; end
            end else begin
                g = m_grant(id);
                for (int i = 0; i < nreq[id]; i++) begin
                    if (cur_v[id][i]) begin m_v[id][i] = 1'b1; m_d[id][i] = cur_d[id][i]; end
                end
                if (cur_rdy[id] && g >= 0) begin
                    m_v[id][g] = 1'b0;
                    m_ptr[id] = (g + 1) % nreq[id];
                    if (m_cnt[id][g] < cmax[id]) m_cnt[id][g]++;
                end
            end
            drv_v[id] = '0;
        end
        cyc++;
    endtask

    task automatic tick();
        drive_sample();
        advance();
    endtask

    task automatic reset_dut(int id);
        drv_rst[id] = 1'b1;
        tick();
        drv_rst[id] = 1'b0;
    endtask

    task automatic test_reset();
        drv_rst[0] = 1'b1; drv_rst[1] = 1'b1; drv_rdy[0] = 1'b1; drv_rdy[1] = 1'b1;
        tick(); tick();
        drv_rst[0] = 1'b0; drv_rst[1] = 1'b0;
        drive_sample();
        checks++;
        if (rdyo_a !== 2'b11) begin errors++; $display("FAIL reset_ready_a: got %b expected 11", rdyo_a); end
        checks++;
        if (rdyo_b !== 3'b111) begin errors++; $display("FAIL reset_ready_b: got %b expected 111", rdyo_b); end
        checks++;
        if (vo_a !== 1'b0 || vo_b !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b expected 00", vo_a, vo_b); end
        advance();
    endtask

    task automatic test_single();
        bp_lce_cce_req_s o;
        drv_v[0][0] = 1'b1;
        drv_d[0][0] = mk_req(0, 1, paddr_t'(32'h8000_0040));
        drive_sample();
        checks++;
        if (vo_a !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", vo_a); end
        advance();
        drive_sample();
        o = out_a;
        checks++;
        if (vo_a !== 1'b1 || o.hdr.addr !== paddr_t'(32'h8000_0040)) begin
            errors++; $display("FAIL single_send: got v=%b addr=%h expected v=1 addr=8000_0040", vo_a, o.hdr.addr);
        end
        checks++;
        if (rdyo_a[0] !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", rdyo_a[0]); end
        advance();
        drive_sample();
        checks++;
        if (rdyo_a[0] !== 1'b1) begin errors++; $display("FAIL single_ready_again: got %b expected 1", rdyo_a[0]); end
        advance();
    endtask

    task automatic test_contention();
        bp_lce_cce_req_s o;
        paddr_t a [2] = '{paddr_t'(32'h1000), paddr_t'(32'h2000)};
        reset_dut(0);
        drv_v[0] = 3'b011;
        for (int i = 0; i < 2; i++) drv_d[0][i] = mk_req(i, 2, a[i]);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_sample();
            o = out_a;
            checks++;
            if (vo_a !== 1'b1 || o.hdr.addr !== a[i]) begin
                errors++; $display("FAIL contention_order%0d: got v=%b addr=%h expected v=1 addr=%h", i, vo_a, o.hdr.addr, a[i]);
            end
            advance();
        end
        drive_sample();
        checks++;
        if (vo_a !== 1'b0) begin errors++; $display("FAIL contention_drained: got %b expected 0", vo_a); end
        advance();
    endtask

    task automatic test_backpressure();
        bp_lce_cce_req_s o;
        paddr_t a [2] = '{paddr_t'(32'h3000), paddr_t'(32'h4000)};
        drv_rdy[0] = 1'b0;
        drv_v[0] = 3'b011;
        for (int i = 0; i < 2; i++) drv_d[0][i] = mk_req(i, 3, a[i]);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive_sample();
            checks++;
            if (vo_a !== 1'b0 || rdyo_a !== 2'b00) begin
                errors++; $display("FAIL backpressure_hold%0d: got v=%b ready=%b expected v=0 ready=00", c, vo_a, rdyo_a);
            end
            advance();
        end
        drv_rdy[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_sample();
            o = out_a;
            checks++;
            if (vo_a !== 1'b1 || o.hdr.addr !== a[i]) begin
                errors++; $display("FAIL backpressure_release%0d: got v=%b addr=%h expected v=1 addr=%h", i, vo_a, o.hdr.addr, a[i]);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        reset_dut(0);
        for (int c = 0; c < 12; c++) begin
            drv_v[0] = 3'b011;
            for (int i = 0; i < 2; i++) drv_d[0][i] = mk_req(i, c, paddr_t'($urandom()));
            drive_sample();
            if (c >= 1) begin
                checks++;
                if (vo_a !== 1'b1) begin errors++; $display("FAIL back_to_back cyc%0d: got %b expected 1", c, vo_a); end
            end
            advance();
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        drv_rdy[0] = 1'b0;
        drv_v[0] = 3'b011;
        for (int i = 0; i < 2; i++) drv_d[0][i] = mk_req(i, 5, paddr_t'(32'h5000));
        tick();
        reset_dut(0);
        drv_rdy[0] = 1'b1;
        drive_sample();
        checks++;
        if (vo_a !== 1'b0 || rdyo_a !== 2'b11) begin
            errors++; $display("FAIL reset_mid: got v=%b ready=%b expected v=0 ready=11", vo_a, rdyo_a);
        end
        advance();
    endtask

    task automatic test_fairness();
        int waiting [3];
        int s;
        bp_lce_cce_req_s o;
        reset_dut(1);
        drv_rdy[1] = 1'b1;
        for (int i = 0; i < 3; i++) waiting[i] = -1;
        for (int c = 0; c < 40; c++) begin
            drv_v[1][2] = 1'b1;
            drv_d[1][2] = mk_req(2, c, paddr_t'($urandom()));
            for (int i = 0; i < 2; i++) begin
                if (c < 30 && $urandom_range(0, 1) == 1) begin
                    drv_v[1][i] = 1'b1;
                    drv_d[1][i] = mk_req(i, c, paddr_t'($urandom()));
                end
            end
            drive_sample();
            if (vo_b === 1'b1) begin
                o = out_b;
                s = int'(o.data[63:56]);
                for (int i = 0; i < 3; i++) if (waiting[i] >= 0) waiting[i]++;
                if (s < 3) begin
                    checks++;
                    if (waiting[s] < 1 || waiting[s] > 3) begin
                        errors++; $display("FAIL fairness slot%0d cyc%0d: waited %0d sends, expected 1..3", s, c, waiting[s]);
                    end
                    waiting[s] = -1;
                end
            end
            for (int i = 0; i < 3; i++) if (cur_v[1][i]) waiting[i] = 0;
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (waiting[i] != -1) begin errors++; $display("FAIL fairness_starved slot%0d: still waiting %0d, expected served", i, waiting[i]); end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_stats();
        int sends, c;
        reset_dut(0);
        reset_dut(1);
        sends = 0; c = 0;
        while (sends < 10 && c < 40) begin
            drv_v[0][1] = 1'b1;
            drv_d[0][1] = mk_req(1, c, paddr_t'($urandom()));
            drive_sample();
            if (vo_a === 1'b1) sends++;
            advance();
            c++;
        end
        drive_sample();
        checks++;
        if (sends != 10) begin errors++; $display("FAIL stats_budget_a: got %0d sends expected 10", sends); end
        checks++;
`ifdef BP_LCE_REQ_ARB_STATS_EN
        if (cnt_a[63:32] !== 32'd10 || cnt_a[31:0] !== 32'd0) begin
            errors++; $display("FAIL stats_count_a: got %0d/%0d expected 0/10", cnt_a[31:0], cnt_a[63:32]);
        end
`else
        if (cnt_a !== 64'd0) begin errors++; $display("FAIL stats_tied_a: got %h expected 0", cnt_a); end
`endif
        advance();
        sends = 0; c = 0;
        while (sends < 20 && c < 60) begin
            drv_v[1][0] = 1'b1;
            drv_d[1][0] = mk_req(0, c, paddr_t'($urandom()));
            drive_sample();
            if (vo_b === 1'b1) sends++;
            advance();
            c++;
        end
        drive_sample();
        checks++;
        if (sends != 20) begin errors++; $display("FAIL stats_budget_b: got %0d sends expected 20", sends); end
        checks++;
`ifdef BP_LCE_REQ_ARB_STATS_EN
        if (cnt_b[3:0] !== 4'd15) begin errors++; $display("FAIL stats_saturate_b: got %0d expected 15", cnt_b[3:0]); end
`else
        if (cnt_b !== 12'd0) begin errors++; $display("FAIL stats_tied_b: got %h expected 0", cnt_b); end
`endif
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int id = 0; id < 2; id++) begin
                drv_rst[id] = ($urandom_range(0, 63) == 0);
                drv_rdy[id] = ($urandom_range(0, 9) < 7);
                for (int i = 0; i < nreq[id]; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        drv_v[id][i] = 1'b1;
                        drv_d[id][i] = mk_req(i, c, paddr_t'({$urandom(), $urandom()}));
                    end
                end
            end
            tick();
        end
        drv_rst[0] = 1'b0; drv_rst[1] = 1'b0;
        drv_rdy[0] = 1'b1; drv_rdy[1] = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        model_reset();
        for (int id = 0; id < 2; id++) begin
            drv_v[id] = '0; drv_rdy[id] = 1'b0; drv_rst[id] = 1'b1;
            for (int i = 0; i < 3; i++) drv_d[id][i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_fairness();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
